escalonador_paradas: RTL
========================

# escalonador_paradas

Parametrised stop scheduler for the cargo elevator: holds up to `PROFUNDIDADE` pending transport requests (origin floor → destination floor) for an `N_ANDARES`-floor shaft and picks the next stop with a sweep (SCAN) policy. Origins must be collected before their destinations are served. It sits between the request front end (serial/entry control) and the movement controller. It replaces the fixed 4-floor destination RAM, adding duplicate merging, pickup/drop-off flags per stop and automatic direction reversal.

## Interface
- `N_ANDARES`, default 4: number of floors (≥2).
- `PROFUNDIDADE`, default 8: request table entries (≥2).
- `AW`, default `$clog2(N_ANDARES)`: floor index width.

- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valido`  in  1  request offered.
- `req_origem`  in  AW  pickup floor.
- `req_destino`  in  AW  drop-off floor.
- `req_pronto`  out  1  table can accept (= not full).
- `req_erro`  out  1  1-cycle pulse: request rejected (origem==destino or floor ≥ N_ANDARES).
- `req_dup`  out  1  1-cycle pulse: request merged into identical pending, uncollected entry.
- `andar_atual`  in  AW  current floor from sensors.
- `atendido`  in  1  1-cycle pulse: stop at `andar_atual` finished loading/unloading.
- `prox_parada`  out  AW  next stop.
- `prox_valida`  out  1  `prox_parada`/flags are current.
- `tem_destino`  out  1  at least one floor has demand.
- `sobe`  out  1  sweep direction, 1 = up.
- `eh_origem`  out  1  next stop has a pending pickup (coloca objetos).
- `tem_entrega`  out  1  next stop has a pending drop-off (tira objetos).
- `ocupacao`  out  $clog2(PROFUNDIDADE+1)  valid entries.

## Operation
- Entry: {valido, coletado, origem, destino}.
- `demanda[f]` (combinational) = OR over valid entries of (!coletado & origem==f) | (coletado & destino==f).
- Accept when `req_valido & req_pronto`, request legal, no duplicate: write lowest-index free slot, coletado=0.
- Illegal: `req_erro`, no write. Duplicate: `req_dup`, no write. Both are evaluated only on a handshake cycle.
- `atendido` at floor f:
  - Entries with coletado & destino==f are freed.
  - Entries with !coletado & origem==f become coletado.
  - An entry with the same origem and destino is impossible.
- FSM `OCIOSO` / `VARRE` / `PRONTO`:
  - Any table write, `atendido`, or change of `andar_atual` moves the FSM to `VARRE`. This aborts any scan in progress. The cursor loads `andar_atual` and the direction loads `sobe`.
  - `VARRE`, one floor per cycle: if `demanda[cursor]`, latch `prox_parada`=cursor, `eh_origem`, `tem_entrega`, set `tem_destino`=1, and go to `PRONTO`. Otherwise step the cursor in the current direction.
  - At floor 0 or N_ANDARES-1 the scan reverses and `sobe` toggles.
  - After 2·N_ANDARES-1 empty checks: `tem_destino`=0 and go to `OCIOSO`.
- `prox_valida`=1 only in `PRONTO`. During `VARRE`, `prox_parada`, `sobe` and the flags hold their previous values.

## Timing
- Reset values: `prox_parada`=0, `prox_valida`=0, `tem_destino`=0, `sobe`=1, `eh_origem`=0, `tem_entrega`=0, `req_erro`=0, `req_dup`=0, `ocupacao`=0, `req_pronto`=1. Table is all invalid, FSM is `OCIOSO`.
- Reset mid-scan or mid-handshake discards everything with no pulses.
- Accepted request updates the table at the clock edge. `VARRE` starts the next cycle. A demand k floors ahead along the sweep gives `prox_valida` k+1 cycles after `VARRE` entry.
- `req_erro`/`req_dup` are asserted the cycle after the handshake.
- `req_pronto` is combinational from the table: 0 when `ocupacao`==PROFUNDIDADE. A request offered while full is ignored, with no pulse.
- Request and `atendido` in the same cycle: `atendido` is applied first. A slot it frees is not reusable until the next cycle.
- A new request with origem==`andar_atual` in the same cycle as `atendido` stays uncollected, so the rescan returns `andar_atual` again.

## Structure
- Package `escalonador_pkg`: FSM state enum; entry struct type; `proximo_andar(cursor, sobe)` step/reverse function.
- Sub-module `tabela_pedidos`: entry storage, free-slot priority encoder, duplicate match, `atendido` update, `demanda` mask, `ocupacao`.
- Top holds the scan FSM and output registers.

## Test plan
- Reset, then request (1→3) with `andar_atual`=0, `sobe`=1 → `prox_parada`=1, `eh_origem`=1, `tem_entrega`=0, `prox_valida` 2 cycles after `VARRE` entry. `atendido` at 1 → `prox_parada`=3, `tem_entrega`=1. `atendido` at 3 → `tem_destino`=0, `ocupacao`=0.
- At floor 2 with `sobe`=1, a single request (1→0) → sweep reaches 3, `sobe` toggles to 0, `prox_parada`=1.
- Request (2→2) → `req_erro`, `ocupacao` unchanged. Request (1→3) sent twice → second gives `req_dup`, `ocupacao`=1.
- Fill 8 requests → `req_pronto`=0 and a 9th is ignored. `atendido` that frees an entry and a request in the same cycle → request is held by `req_pronto`=0 and accepted the next cycle.
- Change `andar_atual` mid-`VARRE` → scan restarts from the new floor with no stale `prox_valida`. Assert `reset` mid-scan → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/escalonador_paradas_pkg.sv
// escalonador_pkg
// Shared types for the cargo elevator stop scheduler:
//   estado_t      scan FSM states (OCIOSO / VARRE / PRONTO)
//   entrada_t     one pending transport request in the table
//   passo_t       result of one cursor step (floor + direction)
//   proximo_andar step the scan cursor one floor, reversing at the shaft ends
// Floors are stored at a fixed width (ANDAR_W) so the types can live here
// independently of the N_ANDARES parameter of each instance.
package escalonador_pkg;

  localparam int ANDAR_W = 8;

  typedef logic [ANDAR_W-1:0] andar_t;

  localparam andar_t ANDAR_UM = ANDAR_W'(1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    VARRE  = 2'd1,
    PRONTO = 2'd2
  } estado_t;

  typedef struct packed {
    logic   valido;
    logic   coletado;
    andar_t origem;
    andar_t destino;
  } entrada_t;

  typedef struct packed {
    andar_t andar;
    logic   sobe;
  } passo_t;

  // One step of the sweep. Hitting the top (ultimo) or floor 0 bounces the
  // cursor back one floor and flips the direction in the same step, so the
  // end floor itself is examined only once per pass.
  function automatic passo_t proximo_andar(input andar_t cursor,
                                           input logic   sobe,
                                           input andar_t ultimo);
    passo_t passo;
    if (sobe) begin
      if (cursor >= ultimo) begin
        passo.andar = ultimo - ANDAR_UM;
        passo.sobe  = 1'b0;
      end else begin
        passo.andar = cursor + ANDAR_UM;
        passo.sobe  = 1'b1;
      end
    end else begin
      if (cursor == '0) begin
        passo.andar = ANDAR_UM;
        passo.sobe  = 1'b1;
      end else begin
        passo.andar = cursor - ANDAR_UM;
        passo.sobe  = 1'b0;
      end
    end
    return passo;
  endfunction

endpackage

// File: rtl/escalonador_paradas_if.sv
// escalonador_paradas_if
// Request handshake, floor feedback and next-stop outputs of the scheduler.
//   master : request front end / movement controller side
//   slave  : the scheduler (escalonador_paradas)
// Signals: req_valido/req_origem/req_destino -> req_pronto/req_erro/req_dup,
// andar_atual/atendido from the car, prox_parada/prox_valida/tem_destino/
// sobe/eh_origem/tem_entrega/ocupacao towards the controller.
interface escalonador_paradas_if #(
  parameter int N_ANDARES    = 4,
  parameter int PROFUNDIDADE = 8,
  parameter int AW           = $clog2(N_ANDARES),
  parameter int OW           = $clog2(PROFUNDIDADE + 1)
);

  logic          req_valido;
  logic [AW-1:0] req_origem;
  logic [AW-1:0] req_destino;
  logic          req_pronto;
  logic          req_erro;
  logic          req_dup;
  logic [AW-1:0] andar_atual;
  logic          atendido;
  logic [AW-1:0] prox_parada;
  logic          prox_valida;
  logic          tem_destino;
  logic          sobe;
  logic          eh_origem;
  logic          tem_entrega;
  logic [OW-1:0] ocupacao;

  modport master (
    output req_valido, req_origem, req_destino, andar_atual, atendido,
    input  req_pronto, req_erro, req_dup, prox_parada, prox_valida,
           tem_destino, sobe, eh_origem, tem_entrega, ocupacao
  );

  modport slave (
    input  req_valido, req_origem, req_destino, andar_atual, atendido,
    output req_pronto, req_erro, req_dup, prox_parada, prox_valida,
           tem_destino, sobe, eh_origem, tem_entrega, ocupacao
  );

endinterface

// File: rtl/tabela_pedidos.sv
// tabela_pedidos
// Storage for up to PROFUNDIDADE pending requests (origin -> destination).
// Inputs : clock, reset, req_valido/req_origem/req_destino, andar_atual, atendido
// Outputs: req_pronto (not full), req_erro/req_dup (registered pulses),
//          gravou (a request is written this cycle), demanda/dem_origem/
//          dem_entrega (per-floor demand masks), ocupacao (valid entries)
module tabela_pedidos
  import escalonador_pkg::*;
#(
  parameter int N_ANDARES    = 4,
  parameter int PROFUNDIDADE = 8,
  parameter int AW           = $clog2(N_ANDARES),
  parameter int OW           = $clog2(PROFUNDIDADE + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valido,
  input  logic [AW-1:0]        req_origem,
  input  logic [AW-1:0]        req_destino,
  input  logic [AW-1:0]        andar_atual,
  input  logic                 atendido,
  output logic                 req_pronto,
  output logic                 req_erro,
  output logic                 req_dup,
  output logic                 gravou,
  output logic [N_ANDARES-1:0] demanda,
  output logic [N_ANDARES-1:0] dem_origem,
  output logic [N_ANDARES-1:0] dem_entrega,
  output logic [OW-1:0]        ocupacao
);

  localparam int     IW        = $clog2(PROFUNDIDADE);
  localparam andar_t N_ANDAR_T = ANDAR_W'(N_ANDARES);

  entrada_t      tabela      [PROFUNDIDADE];
  entrada_t      tabela_prox [PROFUNDIDADE];
  andar_t        origem_ext;
  andar_t        destino_ext;
  andar_t        andar_ext;
  logic          handshake;
  logic          legal;
  logic          duplicado;
  logic          livre_ok;
  logic [IW-1:0] livre_idx;
  logic [OW-1:0] contagem;
  logic          erro_q;
  logic          dup_q;

  assign origem_ext  = ANDAR_W'(req_origem);
  assign destino_ext = ANDAR_W'(req_destino);
  assign andar_ext   = ANDAR_W'(andar_atual);

  assign req_pronto = (contagem != OW'(PROFUNDIDADE));
  assign handshake  = req_valido & req_pronto;
  assign legal      = (origem_ext != destino_ext) &&
                      (origem_ext < N_ANDAR_T) && (destino_ext < N_ANDAR_T);
  assign gravou     = handshake & legal & ~duplicado & livre_ok;
  assign ocupacao   = contagem;
  assign req_erro   = erro_q;
  assign req_dup    = dup_q;

  // Free-slot search uses the valid bits before this cycle's atendido, so a
  // slot freed now only becomes reusable next cycle. The duplicate search
  // instead sees atendido applied first: an entry being collected right now
  // no longer counts as an identical uncollected request.
  always_comb begin
    livre_ok  = 1'b0;
    livre_idx = '0;
    duplicado = 1'b0;
    contagem  = '0;
    for (int i = PROFUNDIDADE - 1; i >= 0; i--) begin
      if (!tabela[i].valido) begin
        livre_ok  = 1'b1;
        livre_idx = IW'(i);
      end
    end
    for (int i = 0; i < PROFUNDIDADE; i++) begin
      if (tabela[i].valido) begin
        contagem = contagem + 1'b1;
      end
      if (tabela[i].valido && !tabela[i].coletado &&
          tabela[i].origem == origem_ext && tabela[i].destino == destino_ext &&
          !(atendido && tabela[i].origem == andar_ext)) begin
        duplicado = 1'b1;
      end
    end
  end

  // A floor has demand when an uncollected entry starts there (pickup) or a
  // collected entry ends there (drop-off).
  always_comb begin
    dem_origem  = '0;
    dem_entrega = '0;
    for (int f = 0; f < N_ANDARES; f++) begin
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        if (tabela[i].valido && !tabela[i].coletado &&
            tabela[i].origem == ANDAR_W'(f)) begin
          dem_origem[f] = 1'b1;
        end
        if (tabela[i].valido && tabela[i].coletado &&
            tabela[i].destino == ANDAR_W'(f)) begin
          dem_entrega[f] = 1'b1;
        end
      end
    end
    demanda = dem_origem | dem_entrega;
  end

  // Next table contents: atendido frees delivered entries and marks picked-up
  // ones, then an accepted request lands in the lowest free slot.
  always_comb begin
    for (int i = 0; i < PROFUNDIDADE; i++) begin
      tabela_prox[i] = tabela[i];
      if (atendido && tabela[i].valido) begin
        if (tabela[i].coletado && tabela[i].destino == andar_ext) begin
          tabela_prox[i] = '0;
        end else if (!tabela[i].coletado && tabela[i].origem == andar_ext) begin
          tabela_prox[i].coletado = 1'b1;
        end
      end
    end
    if (gravou) begin
      tabela_prox[livre_idx] = '{valido: 1'b1, coletado: 1'b0,
                                 origem: origem_ext, destino: destino_ext};
    end
  end

  // Table registers and the one-cycle reject/merge pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        tabela[i] <= '0;
      end
      erro_q <= 1'b0;
      dup_q  <= 1'b0;
    end else begin
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        tabela[i] <= tabela_prox[i];
      end
      erro_q <= handshake & ~legal;
      dup_q  <= handshake & legal & duplicado;
    end
  end

endmodule

// File: rtl/escalonador_paradas.sv
// escalonador_paradas
// Stop scheduler for the cargo elevator: keeps the request table and sweeps
// the shaft (SCAN) to choose the next stop.
// Ports: clock, reset (async, active-high), bus (escalonador_paradas_if.slave)
//   carrying the request handshake, car floor/atendido feedback and the
//   registered next-stop outputs.
module escalonador_paradas
  import escalonador_pkg::*;
#(
  parameter int N_ANDARES    = 4,
  parameter int PROFUNDIDADE = 8,
  parameter int AW           = $clog2(N_ANDARES)
) (
  input logic                   clock,
  input logic                   reset,
  escalonador_paradas_if.slave  bus
);

  localparam int          CW        = $clog2(2 * N_ANDARES);
  localparam logic [CW-1:0] LIMITE  = CW'(2 * N_ANDARES - 2);
  localparam andar_t      ULTIMO    = ANDAR_W'(N_ANDARES - 1);
  localparam andar_t      N_ANDAR_T = ANDAR_W'(N_ANDARES);

  logic                 gravou;
  logic [N_ANDARES-1:0] demanda;
  logic [N_ANDARES-1:0] dem_origem;
  logic [N_ANDARES-1:0] dem_entrega;
  andar_t               andar_ext;
  andar_t               andar_ant;
  andar_t               cursor;
  logic                 dir;
  logic [CW-1:0]        vazios;
  estado_t              estado;
  logic [AW-1:0]        prox_parada_q;
  logic                 tem_destino_q;
  logic                 sobe_q;
  logic                 eh_origem_q;
  logic                 tem_entrega_q;
  logic                 gatilho;
  logic                 cursor_ok;
  logic [AW-1:0]        cursor_idx;
  passo_t               passo;

  tabela_pedidos #(
    .N_ANDARES    (N_ANDARES),
    .PROFUNDIDADE (PROFUNDIDADE),
    .AW           (AW)
  ) u_tabela (
    .clock       (clock),
    .reset       (reset),
    .req_valido  (bus.req_valido),
    .req_origem  (bus.req_origem),
    .req_destino (bus.req_destino),
    .andar_atual (bus.andar_atual),
    .atendido    (bus.atendido),
    .req_pronto  (bus.req_pronto),
    .req_erro    (bus.req_erro),
    .req_dup     (bus.req_dup),
    .gravou      (gravou),
    .demanda     (demanda),
    .dem_origem  (dem_origem),
    .dem_entrega (dem_entrega),
    .ocupacao    (bus.ocupacao)
  );

  // Anything that can change the answer restarts the sweep from the car.
  assign andar_ext  = ANDAR_W'(bus.andar_atual);
  assign gatilho    = gravou | bus.atendido | (andar_ext != andar_ant);
  assign cursor_idx = cursor[AW-1:0];
  assign cursor_ok  = cursor < N_ANDAR_T;
  assign passo      = proximo_andar(cursor, dir, ULTIMO);

  assign bus.prox_parada = prox_parada_q;
  assign bus.prox_valida = (estado == PRONTO);
  assign bus.tem_destino = tem_destino_q;
  assign bus.sobe        = sobe_q;
  assign bus.eh_origem   = eh_origem_q;
  assign bus.tem_entrega = tem_entrega_q;

  // Scan FSM. The working direction 'dir' flips at the shaft ends while
  // scanning; the visible 'sobe' only takes it when a stop is latched, so the
  // outputs stay frozen during VARRE. 2*N_ANDARES-1 empty checks cover every
  // floor once in each direction, after which the shaft is known to be idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado        <= OCIOSO;
      cursor        <= '0;
      dir           <= 1'b1;
      vazios        <= '0;
      andar_ant     <= '0;
      prox_parada_q <= '0;
      tem_destino_q <= 1'b0;
      sobe_q        <= 1'b1;
      eh_origem_q   <= 1'b0;
      tem_entrega_q <= 1'b0;
    end else begin
      andar_ant <= andar_ext;
      if (gatilho) begin
        estado <= VARRE;
        cursor <= andar_ext;
        dir    <= sobe_q;
        vazios <= '0;
      end else begin
        case (estado)
          VARRE: begin
            if (cursor_ok && demanda[cursor_idx]) begin
              prox_parada_q <= cursor_idx;
              eh_origem_q   <= dem_origem[cursor_idx];
              tem_entrega_q <= dem_entrega[cursor_idx];
              sobe_q        <= dir;
              tem_destino_q <= 1'b1;
              estado        <= PRONTO;
            end else if (vazios == LIMITE) begin
              tem_destino_q <= 1'b0;
              estado        <= OCIOSO;
            end else begin
              cursor <= passo.andar;
              dir    <= passo.sobe;
              vazios <= vazios + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
